// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Alarm stage behind the 24-h BCD time counter. It compares the
//               live hh:mm:ss against the alarm hh:mm and drives the buzzer.
//               Snooze has a retry limit, and ringing stops by itself after a
//               timeout. Optional hourly chime is enabled by ALARM_CHIME_EN.
// Ports       : CLK_1Hz, RESET (async, active-high)
//               sec0/1, min0/1, hour0/1        live time, BCD units/tens
//               alm_min0/1, alm_hour0/1        alarm setting, BCD
//               ALARM_ARM (level), SNOOZE, STOP (sampled each edge)
//               BUZZER, ALARM_STATE[1:0], SNOOZE_CNT[1:0], CHIME
// Config      : `define ALARM_CHIME_EN -> hourly chime pulse on CHIME,
//               otherwise CHIME is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_controller #(
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_SEC   = 300,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       CLK_1Hz,
  input  logic       RESET,
  input  logic [3:0] sec0,
  input  logic [3:0] sec1,
  input  logic [3:0] min0,
  input  logic [3:0] min1,
  input  logic [3:0] hour0,
  input  logic [3:0] hour1,
  input  logic [3:0] alm_min0,
  input  logic [3:0] alm_min1,
  input  logic [3:0] alm_hour0,
  input  logic [3:0] alm_hour1,
  input  logic       ALARM_ARM,
  input  logic       SNOOZE,
  input  logic       STOP,
  output logic       BUZZER,
  output logic [1:0] ALARM_STATE,
  output logic [1:0] SNOOZE_CNT,
  output logic       CHIME
);

  localparam int RW = $clog2(RING_TIMEOUT + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);

  localparam logic [RW-1:0] c_RING_LAST  = RW'(RING_TIMEOUT - 1);
  localparam logic [SW-1:0] c_SNZ_LOAD   = SW'(SNOOZE_SEC - 1);
  localparam logic [1:0]    c_MAX_SNOOZE = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZED = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [RW-1:0]   r_ring_cnt, w_ring_nxt;
  logic [SW-1:0]   r_snz_cnt, w_snz_nxt;
  logic [1:0]      r_snooze_cnt, w_scnt_nxt;
  logic            r_buzzer;
  logic            w_digits_ok;
  logic            w_match;

  // A corrupt digit anywhere must never fire the alarm, even when the bad
  // digit matches on both sides.
  assign w_digits_ok = (sec0 <= 4'd9) && (sec1 <= 4'd9) &&
                       (min0 <= 4'd9) && (min1 <= 4'd9) &&
                       (hour0 <= 4'd9) && (hour1 <= 4'd9) &&
                       (alm_min0 <= 4'd9) && (alm_min1 <= 4'd9) &&
                       (alm_hour0 <= 4'd9) && (alm_hour1 <= 4'd9);

  assign w_match = w_digits_ok &&
                   ({hour1, hour0, min1, min0} ==
                    {alm_hour1, alm_hour0, alm_min1, alm_min0}) &&
                   (sec1 == 4'd0) && (sec0 == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_ring_nxt  = r_ring_cnt;
    w_snz_nxt   = r_snz_cnt;
    w_scnt_nxt  = r_snooze_cnt;
    case (r_state)
      S_IDLE: begin
        w_scnt_nxt = 2'd0;
        if (ALARM_ARM && w_match) begin
          w_state_nxt = S_RINGING;
          w_ring_nxt  = '0;
        end
      end
      S_RINGING: begin
        if (!ALARM_ARM || STOP || (r_ring_cnt == c_RING_LAST)) begin
          w_state_nxt = S_IDLE;
          w_scnt_nxt  = 2'd0;
        end else if (SNOOZE && (r_snooze_cnt < c_MAX_SNOOZE)) begin
          w_state_nxt = S_SNOOZED;
          w_snz_nxt   = c_SNZ_LOAD;
          w_scnt_nxt  = r_snooze_cnt + 2'd1;
        end else begin
          // Also covers SNOOZE at the limit: the buzzer simply keeps going.
          w_ring_nxt = r_ring_cnt + 1'b1;
        end
      end
      S_SNOOZED: begin
        if (!ALARM_ARM || STOP) begin
          w_state_nxt = S_IDLE;
          w_scnt_nxt  = 2'd0;
        end else if (r_snz_cnt == '0) begin
          w_state_nxt = S_RINGING;
          w_ring_nxt  = '0;
        end else begin
          w_snz_nxt = r_snz_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_scnt_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK_1Hz or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_ring_cnt   <= '0;
      r_snz_cnt    <= '0;
      r_snooze_cnt <= 2'd0;
      r_buzzer     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ring_cnt   <= w_ring_nxt;
      r_snz_cnt    <= w_snz_nxt;
      r_snooze_cnt <= w_scnt_nxt;
      // Buzzer is its own flop but always tracks the RINGING state.
      r_buzzer     <= (w_state_nxt == S_RINGING);
    end
  end

  assign BUZZER      = r_buzzer;
  assign ALARM_STATE = r_state;
  assign SNOOZE_CNT  = r_snooze_cnt;

`ifdef ALARM_CHIME_EN
  logic r_chime;
  logic w_chime_hit;

  assign w_chime_hit = (min1 == 4'd0) && (min0 == 4'd0) &&
                       (sec1 == 4'd0) && (sec0 == 4'd0);

  // Do not chime over the ringing buzzer.
  always_ff @(posedge CLK_1Hz or posedge RESET) begin
    if (RESET) begin
      r_chime <= 1'b0;
    end else begin
      r_chime <= w_chime_hit && (w_state_nxt != S_RINGING);
    end
  end

  assign CHIME = r_chime;
`else
  assign CHIME = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_controller
// Description : Directed self-checking bench for alarm_controller with the
//               default parameters (60 s ring, 300 s snooze, 3 snoozes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_controller;

  logic       CLK_1Hz = 1'b0;
  logic       RESET;
  logic [3:0] sec0, sec1, min0, min1, hour0, hour1;
  logic [3:0] alm_min0, alm_min1, alm_hour0, alm_hour1;
  logic       ALARM_ARM, SNOOZE, STOP;
  logic       BUZZER;
  logic [1:0] ALARM_STATE;
  logic [1:0] SNOOZE_CNT;
  logic       CHIME;

  int total = 0;
  int bad   = 0;

  alarm_controller dut (
    .CLK_1Hz     (CLK_1Hz),
    .RESET       (RESET),
    .sec0        (sec0),
    .sec1        (sec1),
    .min0        (min0),
    .min1        (min1),
    .hour0       (hour0),
    .hour1       (hour1),
    .alm_min0    (alm_min0),
    .alm_min1    (alm_min1),
    .alm_hour0   (alm_hour0),
    .alm_hour1   (alm_hour1),
    .ALARM_ARM   (ALARM_ARM),
    .SNOOZE      (SNOOZE),
    .STOP        (STOP),
    .BUZZER      (BUZZER),
    .ALARM_STATE (ALARM_STATE),
    .SNOOZE_CNT  (SNOOZE_CNT),
    .CHIME       (CHIME)
  );

  always #5 CLK_1Hz = ~CLK_1Hz;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check state, buzzer and snooze count together.
  task automatic chk_all(input string tag, input logic [1:0] st, input logic bz,
                         input logic [1:0] sc);
    chk({tag, ".state"}, {6'd0, ALARM_STATE}, {6'd0, st});
    chk({tag, ".buzz"},  {7'd0, BUZZER},      {7'd0, bz});
    chk({tag, ".scnt"},  {6'd0, SNOOZE_CNT},  {6'd0, sc});
  endtask

  // One clock edge; inputs may be changed afterwards, well before the next.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_1Hz);
      #2;
    end
  endtask

  task automatic set_time(input logic [3:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0,
                          input logic [3:0] s1, input logic [3:0] s0);
    hour1 = h1; hour0 = h0; min1 = m1; min0 = m0; sec1 = s1; sec0 = s0;
  endtask

  initial begin
    RESET = 1'b1;
    ALARM_ARM = 1'b1; SNOOZE = 1'b0; STOP = 1'b0;
    alm_hour1 = 4'd0; alm_hour0 = 4'd7; alm_min1 = 4'd3; alm_min0 = 4'd0;
    set_time(4'd0, 4'd7, 4'd2, 4'd9, 4'd5, 4'd9);
    #3;
    chk_all("reset", 2'd0, 1'b0, 2'd0);
    chk("reset.chime", {7'd0, CHIME}, 8'd0);
    #4 RESET = 1'b0;

    // 07:29:59 -> no ring; 07:30:00 -> ring after that edge
    tick(1);
    chk_all("pre_match", 2'd0, 1'b0, 2'd0);
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk_all("match", 2'd1, 1'b1, 2'd0);

    // Untouched ring lasts exactly 60 cycles
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
    tick(59);
    chk_all("ring59", 2'd1, 1'b1, 2'd0);
    tick(1);
    chk_all("timeout", 2'd0, 1'b0, 2'd0);
    tick(3);
    chk_all("no_retrig", 2'd0, 1'b0, 2'd0);

    // Snooze: 300 cycles low, match during snooze ignored
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk_all("ring2", 2'd1, 1'b1, 2'd0);
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
    tick(4);
    SNOOZE = 1'b1;
    tick(1);
    SNOOZE = 1'b0;
    chk_all("snooze1", 2'd2, 1'b0, 2'd1);
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    tick(1);
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
    tick(298);
    chk_all("snooze299", 2'd2, 1'b0, 2'd1);
    tick(1);
    chk_all("rering1", 2'd1, 1'b1, 2'd1);

    // Second and third snooze, fourth is ignored
    SNOOZE = 1'b1;
    tick(1);
    SNOOZE = 1'b0;
    chk_all("snooze2", 2'd2, 1'b0, 2'd2);
    tick(300);
    chk_all("rering2", 2'd1, 1'b1, 2'd2);
    SNOOZE = 1'b1;
    tick(1);
    SNOOZE = 1'b0;
    chk_all("snooze3", 2'd2, 1'b0, 2'd3);
    tick(300);
    chk_all("rering3", 2'd1, 1'b1, 2'd3);
    SNOOZE = 1'b1;
    tick(1);
    SNOOZE = 1'b0;
    chk_all("snooze4_ign", 2'd1, 1'b1, 2'd3);
    // Ring after the last re-ring was restarted from zero: 2 cycles used so far
    tick(57);
    chk_all("rering3_58", 2'd1, 1'b1, 2'd3);
    STOP = 1'b1;
    tick(1);
    STOP = 1'b0;
    chk_all("stop", 2'd0, 1'b0, 2'd0);

    // STOP and SNOOZE on the same edge -> IDLE
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    tick(1);
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
    chk_all("ring3", 2'd1, 1'b1, 2'd0);
    STOP = 1'b1; SNOOZE = 1'b1;
    tick(1);
    STOP = 1'b0; SNOOZE = 1'b0;
    chk_all("stop_snz", 2'd0, 1'b0, 2'd0);

    // Async reset mid-ring
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    tick(1);
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
    chk_all("ring4", 2'd1, 1'b1, 2'd0);
    RESET = 1'b1;
    #1;
    chk_all("async_rst", 2'd0, 1'b0, 2'd0);
    #1 RESET = 1'b0;
    tick(1);
    chk_all("post_rst", 2'd0, 1'b0, 2'd0);

    // Disarm while ringing, then match while disarmed
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    tick(1);
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
    chk_all("ring5", 2'd1, 1'b1, 2'd0);
    ALARM_ARM = 1'b0;
    tick(1);
    chk_all("disarm", 2'd0, 1'b0, 2'd0);
    set_time(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
    tick(1);
    chk_all("disarmed_match", 2'd0, 1'b0, 2'd0);
    ALARM_ARM = 1'b1;

    // Equal but invalid digits never match
    alm_min0 = 4'hA;
    set_time(4'd0, 4'd7, 4'd3, 4'hA, 4'd0, 4'd0);
    tick(1);
    chk_all("bad_digit", 2'd0, 1'b0, 2'd0);
    alm_min0 = 4'd0;

    // Hourly chime at 14:00:00
    set_time(4'd1, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
    tick(1);
    chk("chime_pre", {7'd0, CHIME}, 8'd0);
    set_time(4'd1, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0);
    tick(1);
`ifdef ALARM_CHIME_EN
    chk("chime_hit", {7'd0, CHIME}, 8'd1);
`else
    chk("chime_hit", {7'd0, CHIME}, 8'd0);
`endif
    chk_all("chime_state", 2'd0, 1'b0, 2'd0);
    set_time(4'd1, 4'd4, 4'd0, 4'd0, 4'd0, 4'd1);
    tick(1);
    chk("chime_post", {7'd0, CHIME}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
